fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 19 +
 rtl/fetch_controller_if.sv | 25 ++
 rtl/fetch_pc_reg.sv | 25 ++
 rtl/fetch_controller.sv | 106 ++++++++++
 tb/tb_fetch_controller.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [63:0] PC_INC    = 64'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0;
  localparam int unsigned BUB_W     = 3;

  // Redirect targets are forced onto a word boundary; the low bits only feed the error flag.
  function automatic logic [63:0] align_target(input logic [63:0] target);
    return {target[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: hazard/branch inputs, instruction memory port and IF/ID outputs.
interface fetch_controller_if;

  logic        stall;
  logic        br_req;
  logic [63:0] br_target;
  logic [31:0] imem_instr;
  logic [63:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        ifid_valid;
  logic        misalign_err;
  logic [15:0] redirect_cnt;

  modport master (
    output stall, br_req, br_target, imem_instr,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, misalign_err, redirect_cnt
  );

  modport slave (
    input  stall, br_req, br_target, imem_instr,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, misalign_err, redirect_cnt
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// 64-bit program counter register with load enable and async active-low reset.
module fetch_pc_reg #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] d_i,
  output logic [63:0] q_o
);

  logic [63:0] pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, stall hold, branch redirect with bubble flush.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned BUBBLES  = 1
) (
  input  logic               clk,
  input  logic               reset,
  fetch_controller_if.slave  bus
);

  localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(BUBBLES - 1);

  fetch_state_t     state_q, state_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic [31:0]      instr_q, instr_d;
  logic [63:0]      ifid_pc_q, ifid_pc_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [15:0]      rcnt_q, rcnt_d;
  logic             pc_load;
  logic [63:0]      pc_d, pc_q;
  logic             do_fetch;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (pc_load),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bub_d     = bub_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    mis_d     = mis_q;
    rcnt_d    = rcnt_q;
    pc_load   = 1'b0;
    pc_d      = pc_q + PC_INC;
    do_fetch  = 1'b0;

    if (bus.br_req) begin
      // A redirect wins over stall in every state and restarts any flush in progress.
      pc_load = 1'b1;
      pc_d    = align_target(bus.br_target);
      valid_d = 1'b0;
      bub_d   = BUB_RELOAD;
      state_d = FLUSH;
      if (bus.br_target[1:0] != 2'b00) mis_d = 1'b1;
      if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
    end else begin
      case (state_q)
        RUN, HOLD: begin
          if (bus.stall) state_d = HOLD;
          else           do_fetch = 1'b1;
        end
        FLUSH: begin
          if (bub_q != '0)     bub_d = bub_q - BUB_W'(1);
          else if (!bus.stall) do_fetch = 1'b1;
        end
        default: state_d = RUN;
      endcase

      if (do_fetch) begin
        pc_load   = 1'b1;
        instr_d   = bus.imem_instr;
        ifid_pc_d = pc_q;
        valid_d   = 1'b1;
        state_d   = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      bub_q     <= '0;
      instr_q   <= INSTR_NOP;
      ifid_pc_q <= 64'h0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      rcnt_q    <= 16'h0;
    end else begin
      state_q   <= state_d;
      bub_q     <= bub_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.ifid_instr   = instr_q;
  assign bus.ifid_pc      = ifid_pc_q;
  assign bus.ifid_valid   = valid_q;
  assign bus.misalign_err = mis_q;
  assign bus.redirect_cnt = rcnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: vector table with scoreboard plus redirect/reset sequences.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  fetch_controller_if bus_a ();
  fetch_controller_if bus_b ();

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  assign bus_a.imem_instr = instr_of(bus_a.imem_addr);
  assign bus_b.imem_instr = instr_of(bus_b.imem_addr);

  fetch_controller #(.RESET_PC(64'h0), .BUBBLES(1)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  fetch_controller #(.RESET_PC(64'h1000), .BUBBLES(3)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    logic        stall;
    logic        br_req;
    logic [63:0] br_target;
    logic [63:0] e_addr;
    logic [63:0] e_ifid_pc;
    logic        e_valid;
    logic [15:0] e_rcnt;
    logic        e_mis;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];
  vec_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input logic s, input logic b, input logic [63:0] t,
                              input logic [63:0] addr, input logic [63:0] ipc,
                              input logic v, input logic [15:0] rc, input logic mis);
    vec_t r;
    r.stall = s; r.br_req = b; r.br_target = t;
    r.e_addr = addr; r.e_ifid_pc = ipc; r.e_valid = v; r.e_rcnt = rc; r.e_mis = mis;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive_a(input logic s, input logic b, input logic [63:0] t);
    bus_a.stall = s; bus_a.br_req = b; bus_a.br_target = t;
  endtask

  task automatic drive_b(input logic s, input logic b, input logic [63:0] t);
    bus_b.stall = s; bus_b.br_req = b; bus_b.br_target = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t e;

    //            stall br  target                 addr                   ifid_pc                valid rcnt mis
    vecs[0]  = mk(0, 0, 64'h0,                 64'h4,                 64'h0,                 1, 0, 0);
    vecs[1]  = mk(0, 0, 64'h0,                 64'h8,                 64'h4,                 1, 0, 0);
    vecs[2]  = mk(1, 0, 64'h0,                 64'h8,                 64'h4,                 1, 0, 0);
    vecs[3]  = mk(1, 0, 64'h0,                 64'h8,                 64'h4,                 1, 0, 0);
    vecs[4]  = mk(1, 0, 64'h0,                 64'h8,                 64'h4,                 1, 0, 0);
    vecs[5]  = mk(0, 0, 64'h0,                 64'hC,                 64'h8,                 1, 0, 0);
    vecs[6]  = mk(0, 0, 64'h0,                 64'h10,                64'hC,                 1, 0, 0);
    vecs[7]  = mk(1, 1, 64'h100,               64'h100,               64'hC,                 0, 1, 0);
    vecs[8]  = mk(0, 0, 64'h0,                 64'h104,               64'h100,               1, 1, 0);
    vecs[9]  = mk(0, 0, 64'h0,                 64'h108,               64'h104,               1, 1, 0);
    vecs[10] = mk(0, 1, 64'h103,               64'h100,               64'h104,               0, 2, 1);
    vecs[11] = mk(1, 0, 64'h0,                 64'h100,               64'h104,               0, 2, 1);
    vecs[12] = mk(0, 0, 64'h0,                 64'h104,               64'h100,               1, 2, 1);
    vecs[13] = mk(0, 0, 64'h0,                 64'h108,               64'h104,               1, 2, 1);
    vecs[14] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h104,           0, 3, 1);
    vecs[15] = mk(0, 0, 64'h0,                 64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, 1, 3, 1);
    vecs[16] = mk(0, 0, 64'h0,                 64'h4,                 64'h0,                 1, 3, 1);

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(0, 0, 64'h0);
    drive_b(0, 0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;

    check("a_rst addr",  bus_a.imem_addr,    64'h0);
    check("a_rst pc",    bus_a.ifid_pc,      64'h0);
    check("a_rst instr", bus_a.ifid_instr,   64'h0);
    check("a_rst valid", bus_a.ifid_valid,   64'h0);
    check("a_rst rcnt",  bus_a.redirect_cnt, 64'h0);
    check("a_rst mis",   bus_a.misalign_err, 64'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive_a(vecs[i].stall, vecs[i].br_req, vecs[i].br_target);
      sb_q.push_back(vecs[i]);
      tick();
      e = sb_q.pop_front();
      check($sformatf("v%0d addr", i),  bus_a.imem_addr,    e.e_addr);
      check($sformatf("v%0d pc", i),    bus_a.ifid_pc,      e.e_ifid_pc);
      check($sformatf("v%0d valid", i), bus_a.ifid_valid,   64'(e.e_valid));
      check($sformatf("v%0d instr", i), bus_a.ifid_instr,   64'(instr_of(e.e_ifid_pc)));
      check($sformatf("v%0d rcnt", i),  bus_a.redirect_cnt, 64'(e.e_rcnt));
      check($sformatf("v%0d mis", i),   bus_a.misalign_err, 64'(e.e_mis));
    end

    drive_a(0, 0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("mis_sticky %0d", i), bus_a.misalign_err, 64'h1);
    end

    // Redirect every cycle until the counter reaches its ceiling, then once more.
    drive_a(0, 1, 64'h40);
    repeat (65532) @(posedge clk);
    #1;
    check("sat reach", bus_a.redirect_cnt, 64'hFFFF);
    tick();
    check("sat hold",  bus_a.redirect_cnt, 64'hFFFF);
    check("sat addr",  bus_a.imem_addr,    64'h40);
    drive_a(0, 0, 64'h0);

    rst_b = 1'b1;
    check("b_rst addr", bus_b.imem_addr, 64'h1000);
    tick();
    check("b_first pc",    bus_b.ifid_pc,    64'h1000);
    check("b_first valid", bus_b.ifid_valid, 64'h1);
    check("b_first addr",  bus_b.imem_addr,  64'h1004);

    drive_b(0, 1, 64'h200);
    tick();
    check("b_br1 addr",  bus_b.imem_addr,  64'h200);
    check("b_br1 valid", bus_b.ifid_valid, 64'h0);
    drive_b(0, 1, 64'h300);
    tick();
    check("b_br2 addr",  bus_b.imem_addr,    64'h300);
    check("b_br2 valid", bus_b.ifid_valid,   64'h0);
    check("b_br2 rcnt",  bus_b.redirect_cnt, 64'h2);
    drive_b(0, 0, 64'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("b_bub%0d valid", k), bus_b.ifid_valid, 64'h0);
      check($sformatf("b_bub%0d addr", k),  bus_b.imem_addr,  64'h300);
      check($sformatf("b_bub%0d no200", k), 64'(bus_b.ifid_pc == 64'h200), 64'h0);
    end
    tick();
    check("b_tgt valid", bus_b.ifid_valid, 64'h1);
    check("b_tgt pc",    bus_b.ifid_pc,    64'h300);
    check("b_tgt instr", bus_b.ifid_instr, 64'(instr_of(64'h300)));
    check("b_tgt addr",  bus_b.imem_addr,  64'h304);

    drive_b(0, 1, 64'h400);
    tick();
    drive_b(0, 0, 64'h0);
    tick();
    check("b_flush valid", bus_b.ifid_valid, 64'h0);
    #3;
    rst_b = 1'b0;
    #1;
    check("b_async addr",  bus_b.imem_addr,    64'h1000);
    check("b_async pc",    bus_b.ifid_pc,      64'h0);
    check("b_async instr", bus_b.ifid_instr,   64'h0);
    check("b_async valid", bus_b.ifid_valid,   64'h0);
    check("b_async rcnt",  bus_b.redirect_cnt, 64'h0);
    check("b_async mis",   bus_b.misalign_err, 64'h0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    check("b_rel pc",    bus_b.ifid_pc,    64'h1000);
    check("b_rel valid", bus_b.ifid_valid, 64'h1);
    check("b_rel addr",  bus_b.imem_addr,  64'h1004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
